// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: state encodings and default data width.
package div_unit_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if the shifted remainder is large enough.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  msb_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  qbit_o
);

  logic [DATA_WIDTH:0] rem_shift;
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    rem_shift = {rem_i, msb_i};
    trial     = rem_shift - {1'b0, divisor_i};
    qbit_o    = ~trial[DATA_WIDTH];
    // On a failed trial the shifted remainder is below the divisor, so its top bit is zero.
    rem_o     = qbit_o ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider with its execute-stage sequencer: one quotient bit per cycle,
// result held in DONE until the memory stage takes it, abandoned on any pipeline flush.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_enable,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] div_x,
  input  logic [DATA_WIDTH-1:0] div_y,
  input  logic                  ms_allowin,
  input  logic                  flush,
  output logic                  div_complete,
  output logic [DATA_WIDTH-1:0] div_result,
  output logic [DATA_WIDTH-1:0] mod_result
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [DATA_WIDTH-1:0] div_res_q, div_res_d;
  logic [DATA_WIDTH-1:0] mod_res_q, mod_res_d;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_qbit;
  logic [DATA_WIDTH-1:0] quot_next;

  function automatic logic [DATA_WIDTH-1:0] fix_sign(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i    (rem_q),
    .msb_i    (dvd_q[DATA_WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

  // Quotient bits shift into the dividend register as its bits are consumed.
  assign quot_next = {dvd_q[DATA_WIDTH-2:0], step_qbit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_res_d = div_res_q;
    mod_res_d = mod_res_q;
    case (state_q)
      DIV_IDLE: begin
        if (!flush && div_enable) begin
          state_d = DIV_BUSY;
          dvd_d   = fix_sign(div_x, div_signed & div_x[DATA_WIDTH-1]);
          dvs_d   = fix_sign(div_y, div_signed & div_y[DATA_WIDTH-1]);
          qneg_d  = div_signed & (div_x[DATA_WIDTH-1] ^ div_y[DATA_WIDTH-1]);
          rneg_d  = div_signed & div_x[DATA_WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      DIV_BUSY: begin
        if (flush || !div_enable) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = quot_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d   = DIV_DONE;
            div_res_d = fix_sign(quot_next, qneg_q);
            mod_res_d = fix_sign(step_rem, rneg_q);
          end
        end
      end
      DIV_DONE: begin
        if (flush || ms_allowin) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      div_res_q <= '0;
      mod_res_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_res_q <= div_res_d;
      mod_res_q <= mod_res_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign div_complete = (state_q == DIV_DONE);
  assign div_result   = div_res_q;
  assign mod_result   = mod_res_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider, with the sequencer that runs it for the execute stage.
- Accepts the execute stage's divide request (enable, sign, rj/rkd operands).
- Computes quotient and remainder over 32 iteration cycles and raises div_complete until the execute stage hands the instruction to memory stage.
- Aborts on any pipeline flush so the shared divider is free for the refetched stream.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- div_enable  input  1  divide/modulo instruction valid in execute stage; held until consumed
- div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
- div_x  input  DATA_WIDTH  dividend (rj value)
- div_y  input  DATA_WIDTH  divisor (rkd value)
- ms_allowin  input  1  memory stage accepts; consumes a completed result
- flush  input  1  OR of excp/ertn/refetch/icacop flush
- div_complete  output  1  result valid; execute stage may leave
- div_result  output  DATA_WIDTH  quotient
- mod_result  output  DATA_WIDTH  remainder

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on reset.
- Reset values:
  - state = IDLE.
  - div_complete = 0.
  - div_result = 0, mod_result = 0.
  - counter = 0.
- States are IDLE, BUSY, DONE.

IDLE:
- If flush = 1, stay in IDLE.
- Else if div_enable = 1:
  - Latch |x| and |y|. Absolute value applies only when div_signed = 1; otherwise the raw operand.
  - Latch q_neg = div_signed & (x[31] ^ y[31]) and r_neg = div_signed & x[31].
  - Clear the partial remainder and set counter = 0.
  - Go to BUSY.

BUSY:
- Each cycle:
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem_shifted - |y| at DATA_WIDTH+1 bits.
  - If trial is non-negative, rem = trial and the quotient bit is 1; else keep rem and the quotient bit is 0.
  - counter increments by 1.
- After the iteration with counter = DATA_WIDTH-1:
  - Register the sign-fixed results: div_result = q_neg ? -q : q, and mod_result = r_neg ? -r : r.
  - Go to DONE.
- flush = 1 or div_enable = 0 → IDLE next cycle, with no result update.

DONE:
- div_complete = 1 (decoded from the state register, no extra cycle).
- ms_allowin = 1 → IDLE next cycle.
- flush = 1 → IDLE next cycle; flush has priority.
- Otherwise hold; results are stable while held.

Latency:
- div_enable first high at cycle N (in IDLE) → div_complete high from cycle N+33.
- div_complete stays high until the cycle after ms_allowin.
- Back-to-back divides: IDLE is re-entered for one cycle, so the next div_complete comes 34 cycles after the previous consume.

Boundary conditions:
- Divide by zero: no exception; results come from the algorithm.
  - Unsigned: q = 0xFFFFFFFF, r = x.
  - Signed: q = 0xFFFFFFFF if x ≥ 0, else 0x00000001; r = x.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0.
- Operands are sampled only in IDLE; later operand changes are ignored.
- Flush and ms_allowin in the same DONE cycle → IDLE (same outcome).
- Flush and div_enable together in IDLE → no start.
- Reset mid-BUSY → IDLE next cycle with all outputs at reset values.

Decomposition:
- Shared package holds:
  - State encodings DIV_IDLE, DIV_BUSY, DIV_DONE (2 bits).
  - DIV_DATA_WIDTH = 32.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, quotient bit.
- div_unit contains the FSM, counter, operand registers and sign fix-up.

Test Plan:
- Unsigned 100 / 7, consume immediately → div_complete rises exactly 33 cycles after enable; div_result = 14, mod_result = 2; IDLE the cycle after ms_allowin.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → div_result = 0xFFFFFFFD (-3), mod_result = 0xFFFFFFFF (-1); unsigned same operands → 0x7FFFFFFC, 1.
- Divide by zero, signed x = -7 → div_result = 0x00000001, mod_result = 0xFFFFFFF9; signed 0x80000000 / -1 → 0x80000000, 0.
- flush pulsed at BUSY cycle 10 → div_complete never rises; a new enable next cycle completes 33 cycles later with correct results for the new operands.
- DONE with ms_allowin held low for 5 cycles and operands changed → div_complete and results stay stable; ms_allowin = 1 → div_complete low next cycle.
- Reset asserted mid-BUSY → next cycle state IDLE, div_complete = 0, results = 0.
